operator_sequencer: RTL

// - Controller for the 4-bit operator/display datapath (operands m,n; 3-bit op select choose 0..4).
// - Latches switch operands on a button, then steps choose through all ops:

---
 rtl/operator_pkg.sv | 19 +
 rtl/operator_sequencer_btn_edge.sv | 60 ++++++
 rtl/operator_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/operator_pkg.sv
// Shared types and constants for operator_sequencer: FSM state encoding and op-select codes.
package operator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int OP_W            = 3;
  localparam int NUM_OPS_DEFAULT = 5;

  localparam logic [OP_W-1:0] OP_0 = 3'd0;
  localparam logic [OP_W-1:0] OP_1 = 3'd1;
  localparam logic [OP_W-1:0] OP_2 = 3'd2;
  localparam logic [OP_W-1:0] OP_3 = 3'd3;
  localparam logic [OP_W-1:0] OP_4 = 3'd4;

endpackage

// File: rtl/operator_sequencer_btn_edge.sv
// Button conditioner: 2-flop synchroniser, optional debounce filter (DEBOUNCE_EN), rising-edge pulse.
module btn_edge #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic sync_a;
  logic sync_b;
  logic level;
  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The filtered level only follows the synchronised input after a full run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_b;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync_b;

  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/operator_sequencer.sv
// Operand latch and op-select stepper for the operator/display datapath (auto dwell or manual step).
// Optional button debounce filtering is enabled with the DEBOUNCE_EN macro.
module operator_sequencer
  import operator_pkg::*;
#(
  parameter int DWELL_CYCLES    = 100_000_000,
  parameter int NUM_OPS         = NUM_OPS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         sw_m,
  input  logic [3:0]         sw_n,
  input  logic               auto_mode,
  input  logic               btn_load,
  input  logic               btn_step,
  input  logic               btn_clr,
  output logic [3:0]         m,
  output logic [3:0]         n,
  output logic [OP_W-1:0]    choose,
  output logic [NUM_OPS-1:0] op_led,
  output logic               active,
  output logic               cycle_done,
  output state_t             fsm_state
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [OP_W-1:0] LAST_OP  = OP_W'(NUM_OPS - 1);

  state_t state_q, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [3:0]         m_d, n_d;
  logic [OP_W-1:0]    choose_d;
  logic [NUM_OPS-1:0] led_d;
  logic               active_d, done_d, adv;
  logic               load_p, step_p, clr_p;

  logic unused_ops;
  assign unused_ops = ^{OP_1, OP_2, OP_3, OP_4};

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_load), .pulse(load_p));
  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_step), .pulse(step_p));
  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clr), .pulse(clr_p));

  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt        <= '0;
      m          <= '0;
      n          <= '0;
      choose     <= OP_0;
      op_led     <= '0;
      active     <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt        <= cnt_d;
      m          <= m_d;
      n          <= n_d;
      choose     <= choose_d;
      op_led     <= led_d;
      active     <= active_d;
      cycle_done <= done_d;
    end
  end

  // Same-cycle priority: clr, then load, then step pulse / dwell terminal.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt;
    m_d      = m;
    n_d      = n;
    choose_d = choose;
    done_d   = 1'b0;
    adv      = 1'b0;
    if (clr_p) begin
      state_d  = IDLE;
      choose_d = OP_0;
      cnt_d    = '0;
    end else if (load_p) begin
      m_d      = sw_m;
      n_d      = sw_n;
      choose_d = OP_0;
      cnt_d    = '0;
      state_d  = auto_mode ? RUN : STEP;
    end else begin
      case (state_q)
        RUN: begin
          if (!auto_mode) begin
            state_d = STEP;
            cnt_d   = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_d = '0;
            adv   = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        STEP: begin
          cnt_d = '0;
          adv   = step_p;
          if (auto_mode) state_d = RUN;
        end
        default: ;
      endcase
    end
    if (adv) begin
      if (choose == LAST_OP) begin
        choose_d = OP_0;
        done_d   = 1'b1;
      end else begin
        choose_d = choose + 1'b1;
      end
    end
    active_d = (state_d != IDLE);
    led_d    = active_d ? (NUM_OPS'(1) << choose_d) : '0;
  end

endmodule
